// File: rtl/pim_pkg.sv
// Shared PIM address mapping, data width and issuer state type.
// The memory controller imports this too, so bank/row decoding has one definition.
package pim_pkg;

    localparam int BANK_LSB = 10;
    localparam int BANK_MSB = 12;
    localparam int ROW_LSB  = 13;
    localparam int ROW_MSB  = 25;
    localparam int ROW_W    = 13;
    localparam int DATA_W   = 512;
    localparam int BANK_W   = BANK_MSB - BANK_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } issuer_state_e;

    // Collapse a response beat into one 32-bit word by XOR-ing all of its lanes.
    function automatic logic [31:0] fold512(input logic [DATA_W-1:0] data);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < DATA_W / 32; i++) begin
            acc = acc ^ data[i*32 +: 32];
        end
        return acc;
    endfunction

endpackage

// File: rtl/pim_row_tracker.sv
// Open-page shadow of the controller: one open bit and one stored row per bank.
// Counts the ACT/PRE pairs a no-skip controller would issue for the request stream.
module pim_row_tracker
    import pim_pkg::*;
#(
    parameter int NUM_BANKS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              upd_i,
    input  logic [BANK_W-1:0] bank_i,
    input  logic [ROW_W-1:0]  row_i,
    output logic              hit_o,
    output logic              miss_o,
    output logic              conflict_o,
    output logic [31:0]       pred_act_o,
    output logic [31:0]       pred_pre_o
);

    logic [NUM_BANKS-1:0] open_q;
    logic [ROW_W-1:0]     row_q [NUM_BANKS];
    logic [31:0]          act_q;
    logic [31:0]          pre_q;
    logic                 bank_open;
    logic                 row_match;

    assign bank_open  = open_q[bank_i];
    assign row_match  = (row_q[bank_i] == row_i);
    assign hit_o      = bank_open && row_match;
    assign conflict_o = bank_open && !row_match;
    assign miss_o     = !bank_open;
    assign pred_act_o = act_q;
    assign pred_pre_o = pre_q;

    // A conflict costs PRE+ACT, a closed bank costs ACT; either way the new row becomes open.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            open_q <= '0;
            act_q  <= '0;
            pre_q  <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                row_q[b] <= '0;
            end
        end else if (upd_i) begin
            open_q[bank_i] <= 1'b1;
            row_q[bank_i]  <= row_i;
            if (!hit_o) begin
                act_q <= act_q + 32'd1;
            end
            if (conflict_o) begin
                pre_q <= pre_q + 32'd1;
            end
        end
    end

endmodule

// File: rtl/pim_stream_issuer.sv
// Issues a strided request stream to pim_system_top after a single start command,
// folds responses into a checksum and reports shadow-model ACT/PRE predictions.
module pim_stream_issuer
    import pim_pkg::*;
#(
    parameter int MAX_OUT   = 4,
    parameter int NUM_BANKS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       cfg_base,
    input  logic [31:0]       cfg_stride,
    input  logic [31:0]       cfg_count,
    output logic              busy,
    output logic              done,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [31:0]       req_addr,
    input  logic              resp_valid,
    output logic              resp_ready,
    input  logic [DATA_W-1:0] resp_data,
    output logic [31:0]       sent_count,
    output logic [31:0]       recv_count,
    output logic [31:0]       cycle_count,
    output logic [31:0]       checksum,
    output logic [31:0]       pred_act,
    output logic [31:0]       pred_pre,
    output logic              err_unexp
);

    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

    issuer_state_e state_q, state_d;

    logic [31:0] count_q;
    logic [31:0] stride_q;
    logic [31:0] addr_q;
    logic [31:0] sent_q;
    logic [31:0] recv_q;
    logic [31:0] cycle_q;
    logic [31:0] checksum_q;
    logic [3:0]  out_q, out_d;
    logic        err_q;

    logic start_acc;
    logic run_active;
    logic req_valid_w;
    logic req_xfer;
    logic resp_hs;
    logic resp_acc;
    logic resp_unexp;
    logic trk_hit;
    logic trk_miss;
    logic trk_conflict;

    assign start_acc   = (state_q == ST_IDLE) && start;
    assign run_active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    // Depends only on registered state, so valid and address hold until the slave takes them.
    assign req_valid_w = (state_q == ST_RUN) && (sent_q < count_q) && (out_q < MAX_OUT_C);
    assign req_xfer    = req_valid_w && req_ready;
    assign resp_hs     = resp_valid && run_active;
    assign resp_acc    = resp_hs && (out_q != 4'd0);
    assign resp_unexp  = resp_hs && (out_q == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cfg_count == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (sent_q == count_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (recv_q == count_q) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out_d = out_q;
        unique case ({req_xfer, resp_acc})
            2'b10:   out_d = out_q + 4'd1;
            2'b01:   out_d = out_q - 4'd1;
            default: out_d = out_q;
        endcase
    end

    // Statistics are cleared only by reset or a new start, so they stay readable after done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= '0;
            stride_q   <= '0;
            addr_q     <= '0;
            sent_q     <= '0;
            recv_q     <= '0;
            cycle_q    <= '0;
            checksum_q <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
        end else if (start_acc) begin
            count_q    <= cfg_count;
            stride_q   <= cfg_stride;
            addr_q     <= cfg_base;
            sent_q     <= '0;
            recv_q     <= '0;
            cycle_q    <= '0;
            checksum_q <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (req_xfer) begin
                addr_q <= addr_q + stride_q;
                sent_q <= sent_q + 32'd1;
            end
            if (resp_acc) begin
                recv_q     <= recv_q + 32'd1;
                checksum_q <= checksum_q ^ fold512(resp_data);
            end
            if (resp_unexp) begin
                err_q <= 1'b1;
            end
            if (run_active) begin
                cycle_q <= cycle_q + 32'd1;
            end
            out_q <= out_d;
        end
    end

    pim_row_tracker #(
        .NUM_BANKS (NUM_BANKS)
    ) u_row_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (start_acc),
        .upd_i      (req_xfer),
        .bank_i     (addr_q[BANK_MSB:BANK_LSB]),
        .row_i      (addr_q[ROW_MSB:ROW_LSB]),
        .hit_o      (trk_hit),
        .miss_o     (trk_miss),
        .conflict_o (trk_conflict),
        .pred_act_o (pred_act),
        .pred_pre_o (pred_pre)
    );

    // Every tracked request must classify as exactly one of hit, miss or conflict.
    assert property (@(posedge clk) disable iff (!rst_n)
        req_xfer |-> $onehot({trk_hit, trk_miss, trk_conflict}));

    assign busy        = run_active;
    assign done        = (state_q == ST_FIN);
    assign req_valid   = req_valid_w;
    assign req_addr    = addr_q;
    assign resp_ready  = run_active;
    assign sent_count  = sent_q;
    assign recv_count  = recv_q;
    assign cycle_count = cycle_q;
    assign checksum    = checksum_q;
    assign err_unexp   = err_q;

endmodule

// File: doc/pim_stream_issuer.md
Name: pim_stream_issuer

Overview:
Hardware request sequencer directly upstream of pim_system_top. It replaces software or bench-driven streaming: after one start command it issues a strided address stream on the req_* handshake, consumes resp_* beats, and folds response data into a checksum. It also keeps an open-page shadow model using the controller's bank/row mapping, so a run reports predicted no-skip ACT/PRE counts next to the DUT counters.

Parameters:
MAX_OUT, 4, maximum outstanding requests (1..15); outstanding counter is 4 bits.
NUM_BANKS, 8, banks tracked by the shadow model; must match the controller.

Ports:
clk  in  1  system clock (DDR tCK domain)
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle start pulse; honoured only when busy=0
cfg_base  in  32  first byte address
cfg_stride  in  32  byte stride between requests
cfg_count  in  32  number of requests
busy  out  1  run in progress
done  out  1  one-cycle pulse when the run completes
req_valid  out  1  request valid to pim_system_top
req_ready  in  1  request ready from pim_system_top
req_addr  out  32  request address
resp_valid  in  1  response valid
resp_ready  out  1  response ready
resp_data  in  512  response data
sent_count  out  32  requests accepted this run
recv_count  out  32  responses accepted this run
cycle_count  out  32  cycles from start acceptance to done
checksum  out  32  XOR of folded responses
pred_act  out  32  shadow-model ACTs
pred_pre  out  32  shadow-model PREs
err_unexp  out  1  sticky: response seen with zero outstanding

Behaviour:
- Reset (rst_n=0 at posedge):
  - All outputs and counters go to 0.
  - State goes to IDLE.
  - Shadow bank table is cleared (all banks closed).
  - Reset mid-run abandons the run with no done pulse. Responses arriving later are refused because resp_ready=0 in IDLE.
- States: IDLE, RUN, DRAIN, FIN.
  - IDLE: start=1 latches cfg_*, clears all statistics, checksum, err_unexp and the shadow table, then goes to RUN (or FIN if cfg_count=0). busy=1 from the next cycle.
  - RUN: issues requests. When sent_count==cfg_count, go to DRAIN.
  - DRAIN: waits until recv_count==cfg_count, then goes to FIN.
  - FIN: done=1 and busy=0 for exactly one cycle, then IDLE. Statistics hold until the next start.
  - A start pulse while busy=1 is ignored.
- Request channel:
  - req_valid=1 in RUN when sent_count<cfg_count and outstanding<MAX_OUT.
  - Once req_valid=1, req_valid and req_addr hold stable until req_ready=1.
  - Transfer happens on req_valid&&req_ready. The next req_valid may assert in the following cycle, giving one request per cycle at full throughput.
  - Address i is cfg_base + i*cfg_stride, computed with a running 32-bit adder; wrap is modulo 2^32.
- Response channel:
  - resp_ready=1 whenever state is RUN or DRAIN; otherwise 0.
  - On resp_valid&&resp_ready with outstanding>0: decrement outstanding, increment recv_count, and update checksum ^= XOR of the sixteen 32-bit words of resp_data.
  - If outstanding==0: set err_unexp, do not count the beat, leave checksum unchanged.
- Outstanding counter:
  - A request transfer and a response acceptance in the same cycle leave it unchanged.
  - Never exceeds MAX_OUT and never underflows.
- cycle_count: increments every cycle while busy=1. It covers start acceptance through the cycle before FIN.
- Shadow model, updated on each request transfer:
  - bank=addr[12:10], row=addr[25:13].
  - Bank open with the same row: no change.
  - Bank open with a different row: pred_pre+1 and pred_act+1; store the new row.
  - Bank closed: pred_act+1; open the bank and store the row.
- Simultaneous cases: cfg_count=1 with the response accepted in the issue cycle is impossible, since response latency is ≥1 cycle. A response on the cycle that moves RUN→DRAIN counts normally.

Decomposition:
- pim_pkg holds: BANK_LSB=10, BANK_MSB=12, ROW_LSB=13, ROW_MSB=25, ROW_W=13, DATA_W=512, the state enum type, and a function fold512 (512→32 XOR).
- The controller and this block both import pim_pkg, so the address mapping has a single source.
- One sub-module: pim_row_tracker (bank open bits plus row table, update strobe, hit/miss/conflict outputs, pred_act/pred_pre counters, clear input).

Test Plan:
- base=0x0004_0000, stride=64, count=3000, zero-wait slave with 1-cycle response: sent=recv=3000, pred_act=188, pred_pre=180, err_unexp=0, exactly one done pulse.
- count=0: done pulses 2 cycles after start, no req_valid, all statistics 0.
- MAX_OUT=4, slave with req_ready=1 that never responds: exactly 4 transfers, then req_valid=0 indefinitely, busy=1. Releasing 4 responses lets the stream resume.
- base=0xFFFF_FFC0, stride=64, count=2: addresses 0xFFFF_FFC0 then 0x0000_0000 (wrap).
- Random req_ready backpressure: req_addr stable while valid&&!ready. Checksum equals the XOR of folded beats sent by the slave, e.g. beats word0=0x1, 0x2, 0x4 (rest 0) give 0x7.
- Reset asserted mid-RUN after 10 transfers: next cycle busy=0, all counters 0, no done pulse. A new start then runs cleanly. An injected response with zero outstanding sets err_unexp.
